bitwise_logic_pipe: RTL and testbench



---
 rtl/bitwise_logic_pipe.sv | 106 ++++++++++
 tb/tb_bitwise_logic_pipe.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bitwise_logic_pipe.sv
// bitwise_logic_pipe: pipelined bitwise logic unit with a running XOR accumulator.
// Stage 0 is combinational (operation select plus accumulator base). Stages
// 1..STAGES are registers that shift together under a single global enable.
// f, parity and out_valid are taken straight from the last stage register.
//
// Handshake: a beat transfers on the input side when in_valid && in_ready, and
// on the output side when out_valid && out_ready. in_ready is combinational and
// equals the global enable (!out_valid || out_ready). While out_valid is high
// and out_ready is low, f/parity/out_valid hold stable and no input is taken.
module bitwise_logic_pipe #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] f,
  output logic             parity,
  output logic [WIDTH-1:0] acc
);

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_XOR  = 3'b010;
  localparam logic [2:0] OP_XNOR = 3'b011;
  localparam logic [2:0] OP_NAND = 3'b100;
  localparam logic [2:0] OP_NOR  = 3'b101;
  localparam logic [2:0] OP_ANDN = 3'b110;
  localparam logic [2:0] OP_ACC  = 3'b111;

  // Index 0 is pipeline stage 1, index STAGES-1 is the output stage.
  logic [STAGES-1:0] stage_vld;
  logic [STAGES-1:0] stage_par;
  logic [WIDTH-1:0]  stage_dat [STAGES];

  logic             en;
  logic             accept;
  logic [WIDTH-1:0] base;
  logic [WIDTH-1:0] r;

  assign out_valid = stage_vld[STAGES-1];
  assign f         = stage_dat[STAGES-1];
  assign parity    = stage_par[STAGES-1];
  assign en        = !out_valid || out_ready;
  assign in_ready  = en;
  assign accept    = in_valid && en;

  // Stage-0 result: selected bitwise operation; ACC folds in the accumulator
  // (or zero when acc_clr is set on the same beat, so a chain can restart).
  always_comb begin
    base = acc_clr ? '0 : acc;
    r    = '0;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_XNOR: r = ~(a ^ b);
      OP_NAND: r = ~(a & b);
      OP_NOR:  r = ~(a | b);
      OP_ANDN: r = a & ~b;
      OP_ACC:  r = base ^ a ^ b;
      default: r = '0;
    endcase
  end

  // Accumulator updates at acceptance so consecutive ACC beats chain without
  // a bubble; acc_clr still clears while the pipe is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (accept && (op == OP_ACC)) begin
      acc <= r;
    end else if (acc_clr) begin
      acc <= '0;
    end
  end

  // Pipeline shift: all stages advance together when enabled; a non-accept
  // cycle inserts a bubble into stage 1 (bubbles are never collapsed).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_vld <= '0;
      stage_par <= '0;
      for (int i = 0; i < STAGES; i++) begin
        stage_dat[i] <= '0;
      end
    end else if (en) begin
      stage_vld[0] <= accept;
      stage_dat[0] <= r;
      stage_par[0] <= ^r;
      for (int i = 1; i < STAGES; i++) begin
        stage_vld[i] <= stage_vld[i-1];
        stage_dat[i] <= stage_dat[i-1];
        stage_par[i] <= stage_par[i-1];
      end
    end
  end

endmodule

// File: tb/tb_bitwise_logic_pipe.sv
// Testbench for bitwise_logic_pipe: vector table, backpressure, randomized
// traffic against a queue-based reference model, mid-stream reset, and a
// second narrow single-stage instance.
module tb_bitwise_logic_pipe;

  localparam int W = 16;
  localparam int S = 2;
  localparam int NV = 12;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         in_valid, in_ready, out_valid, out_ready, acc_clr, parity;
  logic [W-1:0] a, b, f, acc;
  logic [2:0]   op;

  logic         in_valid8, in_ready8, out_valid8, out_ready8, acc_clr8, parity8;
  logic [7:0]   a8, b8, f8, acc8;
  logic [2:0]   op8;

  bitwise_logic_pipe #(.WIDTH(W), .STAGES(S)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .acc_clr(acc_clr), .out_valid(out_valid),
    .out_ready(out_ready), .f(f), .parity(parity), .acc(acc)
  );

  bitwise_logic_pipe #(.WIDTH(8), .STAGES(1)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .op(op8), .acc_clr(acc_clr8), .out_valid(out_valid8),
    .out_ready(out_ready8), .f(f8), .parity(parity8), .acc(acc8)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] model_op(input logic [2:0] o, input logic [W-1:0] x,
                                            input logic [W-1:0] y, input logic [W-1:0] bs);
    case (o)
      3'd0: return x & y;
      3'd1: return x | y;
      3'd2: return x ^ y;
      3'd3: return ~(x ^ y);
      3'd4: return ~(x & y);
      3'd5: return ~(x | y);
      3'd6: return x & ~y;
      default: return bs ^ x ^ y;
    endcase
  endfunction

  logic [W-1:0] exp_q[$];
  logic [W-1:0] acc_m = '0;
  logic         prev_stall = 1'b0;
  logic [W-1:0] prev_f = '0;
  logic         prev_p = 1'b0;

  // Scoreboard: samples 1 time unit before each rising edge, after inputs settle.
  always begin
    logic [W-1:0] e, bs, rr;
    @(negedge clk);
    #4;
    if (!rst_n) begin
      exp_q.delete();
      acc_m      = '0;
      prev_stall = 1'b0;
    end else begin
      check("acc", acc, acc_m);
      check("in_ready", in_ready, !out_valid || out_ready);
      if (prev_stall) begin
        check("stall_valid", out_valid, 1);
        check("stall_f", f, prev_f);
        check("stall_parity", parity, prev_p);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) fail_now("unexpected_beat");
        else begin
          e = exp_q.pop_front();
          check("sb_f", f, e);
          check("sb_parity", parity, ^e);
        end
      end
      if (in_valid && in_ready) begin
        bs = acc_clr ? '0 : acc_m;
        rr = model_op(op, a, b, bs);
        exp_q.push_back(rr);
        if (op == 3'd7) acc_m = rr;
        else if (acc_clr) acc_m = '0;
      end else if (acc_clr) begin
        acc_m = '0;
      end
      prev_stall = out_valid && !out_ready;
      prev_f     = f;
      prev_p     = parity;
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         clr;
    logic [W-1:0] ef;
    logic         ep;
  } vec_t;

  vec_t tbl [NV];

  task automatic drive_beat(input logic [2:0] o, input logic [W-1:0] x,
                            input logic [W-1:0] y, input logic c);
    in_valid = 1'b1;
    op       = o;
    a        = x;
    b        = y;
    acc_clr  = c;
  endtask

  task automatic drive_idle();
    in_valid = 1'b0;
    acc_clr  = 1'b0;
  endtask

  task automatic drain(input string name);
    out_ready = 1'b1;
    drive_idle();
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !out_valid) break;
    end
    check(name, exp_q.size(), 0);
  endtask

  initial begin
    logic [W-1:0] acc_hold;

    tbl[0]  = '{3'd2, 16'hAAAA, 16'h00FF, 1'b0, 16'hAA55, 1'b0};
    tbl[1]  = '{3'd2, 16'h0F0F, 16'h3333, 1'b0, 16'h3C3C, 1'b0};
    tbl[2]  = '{3'd2, 16'h9AB0, 16'h12FF, 1'b0, 16'h884F, 1'b1};
    tbl[3]  = '{3'd0, 16'h9AB0, 16'h12FF, 1'b0, 16'h12B0, 1'b1};
    tbl[4]  = '{3'd1, 16'h9AB0, 16'h12FF, 1'b0, 16'h9AFF, 1'b0};
    tbl[5]  = '{3'd3, 16'h9AB0, 16'h12FF, 1'b0, 16'h77B0, 1'b1};
    tbl[6]  = '{3'd4, 16'h9AB0, 16'h12FF, 1'b0, 16'hED4F, 1'b1};
    tbl[7]  = '{3'd5, 16'h9AB0, 16'h12FF, 1'b0, 16'h6500, 1'b0};
    tbl[8]  = '{3'd6, 16'h9AB0, 16'h12FF, 1'b0, 16'h8800, 1'b0};
    tbl[9]  = '{3'd7, 16'hAAAA, 16'h00FF, 1'b1, 16'hAA55, 1'b0};
    tbl[10] = '{3'd7, 16'h0F0F, 16'h3333, 1'b0, 16'h9669, 1'b0};
    tbl[11] = '{3'd2, 16'hFFFF, 16'h0001, 1'b0, 16'hFFFE, 1'b1};

    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b1; acc_clr = 1'b0; op = 3'd0; a = '0; b = '0;
    in_valid8 = 1'b0; out_ready8 = 1'b1; acc_clr8 = 1'b0; op8 = 3'd0; a8 = '0; b8 = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_f", f, 0);
    check("rst_parity", parity, 0);
    check("rst_acc", acc, 0);
    check("rst_out_valid8", out_valid8, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);
    check("post_rst_out_valid", out_valid, 0);

    // Table: consecutive beats, exact latency of S cycles
    for (int i = 0; i < NV + S; i++) begin
      @(negedge clk);
      if (i >= S) begin
        check("tbl_valid", out_valid, 1);
        check("tbl_f", f, tbl[i-S].ef);
        check("tbl_parity", parity, tbl[i-S].ep);
      end
      if (i < NV) drive_beat(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].clr);
      else drive_idle();
    end
    @(negedge clk);
    check("tbl_drained", out_valid, 0);
    check("acc_chain", acc, 16'h9669);
    acc_clr = 1'b1;
    @(negedge clk);
    acc_clr = 1'b0;
    check("acc_clr_idle", acc, 0);

    // Backpressure: fill, stall 5 cycles offering ACC beats, then drain
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive_beat(3'($urandom_range(0, 6)), W'($urandom), W'($urandom), 1'b0);
      @(negedge clk);
    end
    acc_hold = acc;
    for (int k = 0; k < 5; k++) begin
      drive_beat(3'd7, W'($urandom), W'($urandom), 1'b0);
      @(negedge clk);
      check("bp_in_ready", in_ready, 0);
      check("bp_out_valid", out_valid, 1);
      check("bp_acc", acc, acc_hold);
    end
    drain("bp_drain");

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      op        = 3'($urandom_range(0, 7));
      a         = W'($urandom);
      b         = W'($urandom);
      acc_clr   = ($urandom_range(0, 7) == 0);
      @(negedge clk);
    end
    drain("rand_drain");

    // Mid-stream reset with two beats in flight and acc = 9669
    drive_beat(3'd7, 16'hAAAA, 16'h00FF, 1'b1);
    @(negedge clk);
    drive_beat(3'd7, 16'h0F0F, 16'h3333, 1'b0);
    @(negedge clk);
    drive_idle();
    out_ready = 1'b0;
    check("mid_acc", acc, 16'h9669);
    #2 rst_n = 1'b0;
    #1;
    check("async_out_valid", out_valid, 0);
    check("async_f", f, 0);
    check("async_parity", parity, 0);
    check("async_acc", acc, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("no_stale", out_valid, 0);
    end

    // Narrow single-stage instance: visible the cycle after accept
    @(negedge clk);
    check("w8_idle", out_valid8, 0);
    check("w8_in_ready", in_ready8, 1);
    in_valid8 = 1'b1; op8 = 3'd2; a8 = 8'hA5; b8 = 8'hFF;
    @(negedge clk);
    in_valid8 = 1'b0;
    check("w8_valid", out_valid8, 1);
    check("w8_f", f8, 8'h5A);
    check("w8_parity", parity8, 0);
    check("w8_acc", acc8, 0);
    @(negedge clk);
    check("w8_done", out_valid8, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
